// File: rtl/ws2812b_pkg.sv
// Shared WS2812B timing constants, state encoding and ns-to-cycle conversion
// used by both the strip driver and the receive decoder.
package ws2812b_pkg;

    localparam int T0H_NS        = 400;
    localparam int T1H_NS        = 800;
    localparam int PERIOD_NS     = 1250;
    localparam int RES_NS        = 50_000;
    localparam int BITS_PER_WORD = 24;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } rx_state_e;

    // Rounded conversion; every timing constant fits in 16 bits.
    function automatic logic [15:0] cycles_from_ns(input int clock_mhz, input int ns);
        int c;
        c = (clock_mhz * ns + 500) / 1000;
        return c[15:0];
    endfunction

endpackage

// File: rtl/ws2812b_pulse_meas.sv
// Line front end: synchronises din, detects edges, measures high/low widths
// and strobes once when the line has been low long enough to be a latch gap.
module ws2812b_pulse_meas
    import ws2812b_pkg::*;
#(
    parameter logic [15:0] RES_CYC = 16'd3200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_i,
    output logic        rise_o,
    output logic        fall_o,
    output logic        gap_o,
    output logic [15:0] width_o
);

    logic [1:0]  sync_q;
    logic        din_prev_q;
    logic        din_s;
    logic [15:0] hi_cnt_q, hi_cnt_d;
    logic [15:0] lo_cnt_q, lo_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            din_prev_q <= 1'b0;
            hi_cnt_q   <= 16'd0;
            lo_cnt_q   <= 16'd0;
        end else begin
            sync_q     <= {sync_q[0], din_i};
            din_prev_q <= sync_q[1];
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
        end
    end

    assign din_s  = sync_q[1];
    assign rise_o = din_s & ~din_prev_q;
    assign fall_o = ~din_s & din_prev_q;

    // The edge cycle itself counts, so at the fall hi_cnt equals the high width.
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (rise_o)
            hi_cnt_d = 16'd1;
        else if (din_s && hi_cnt_q != 16'hFFFF)
            hi_cnt_d = hi_cnt_q + 16'd1;
        if (fall_o)
            lo_cnt_d = 16'd1;
        else if (!din_s && lo_cnt_q != 16'hFFFF)
            lo_cnt_d = lo_cnt_q + 16'd1;
    end

    assign width_o = hi_cnt_q;
    assign gap_o   = ~din_s & (lo_cnt_q == RES_CYC - 16'd1);

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receive decoder: classifies pulses into bits, assembles MSB-first
// 24-bit GRB words onto a valid/ready output and flags frame gaps and errors.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int CLOCK_MHZ     = 64,
    parameter int THRESH_NS     = 625,
    parameter int MIN_PULSE_NS  = 150,
    parameter int RES_DETECT_NS = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic        frame_end,
    output logic        err_short,
    output logic        err_partial,
    output logic        overflow
);

    localparam logic [15:0] THRESH_CYC = cycles_from_ns(CLOCK_MHZ, THRESH_NS);
    localparam logic [15:0] MIN_CYC    = cycles_from_ns(CLOCK_MHZ, MIN_PULSE_NS);
    localparam logic [15:0] RES_CYC    = cycles_from_ns(CLOCK_MHZ, RES_DETECT_NS);

    logic        rise, fall, gap;
    logic [15:0] width;

    ws2812b_pulse_meas #(
        .RES_CYC(RES_CYC)
    ) u_meas (
        .clk    (clk),
        .rst    (rst),
        .din_i  (din),
        .rise_o (rise),
        .fall_o (fall),
        .gap_o  (gap),
        .width_o(width)
    );

    rx_state_e   state_q, state_d;
    logic        active_q, active_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [23:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_end_q, frame_end_d;
    logic        err_short_q, err_short_d;
    logic        err_partial_q, err_partial_d;
    logic        overflow_q, overflow_d;
    logic        word_done;
    logic [23:0] new_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_GAP;
            active_q      <= 1'b0;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 24'd0;
            data_q        <= 24'd0;
            valid_q       <= 1'b0;
            frame_end_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_partial_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_end_q   <= frame_end_d;
            err_short_q   <= err_short_d;
            err_partial_q <= err_partial_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = valid_q;
        frame_end_d   = 1'b0;
        err_short_d   = 1'b0;
        err_partial_d = 1'b0;
        overflow_d    = 1'b0;
        word_done     = 1'b0;
        new_word      = {shift_q[22:0], (width >= THRESH_CYC)};

        if (valid_q && ready)
            valid_d = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    active_d  = 1'b1;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    if (width < MIN_CYC) begin
                        err_short_d = 1'b1;
                    end else begin
                        shift_d = new_word;
                        if (bit_cnt_q == 5'(BITS_PER_WORD - 1)) begin
                            bit_cnt_d = 5'd0;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (gap) begin
                    frame_end_d   = active_q;
                    err_partial_d = (bit_cnt_q != 5'd0);
                    bit_cnt_d     = 5'd0;
                    active_d      = 1'b0;
                    state_d       = ST_GAP;
                end
            end
            default: state_d = ST_GAP;
        endcase

        // An unconsumed word wins; a same-cycle accept lets the new word follow with no bubble.
        if (word_done) begin
            if (valid_q && !ready) begin
                overflow_d = 1'b1;
            end else begin
                data_d  = new_word;
                valid_d = 1'b1;
            end
        end
    end

    assign data_out    = data_q;
    assign valid       = valid_q;
    assign frame_end   = frame_end_q;
    assign err_short   = err_short_q;
    assign err_partial = err_partial_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Randomised self-checking bench for ws2812b_rx against a pulse-level model.
module tb_ws2812b_rx;

    localparam int MHZ    = 64;
    localparam int MIN    = (MHZ * 150 + 500) / 1000;
    localparam int THRESH = (MHZ * 625 + 500) / 1000;
    localparam int RES    = (MHZ * 50_000 + 500) / 1000;
    localparam int GAP_LO = 3300;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        ready;
    logic [23:0] data_out;
    logic        valid, frame_end, err_short, err_partial, overflow;

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .frame_end  (frame_end),
        .err_short  (err_short),
        .err_partial(err_partial),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Monitor
    int          cyc = 0;
    logic [23:0] got_q[$];
    int          cnt_frame = 0, cnt_short = 0, cnt_partial = 0, cnt_ovf = 0;
    int          accept_cyc = 0, frame_cyc = 0, fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                got_q.push_back(data_out);
                accept_cyc = cyc;
            end
            if (frame_end)   begin cnt_frame++; frame_cyc = cyc; end
            if (err_short)   cnt_short++;
            if (err_partial) cnt_partial++;
            if (overflow)    cnt_ovf++;
        end
    end

    // Reference model: pulse widths -> bits -> words / events
    logic [23:0] exp_q[$];
    int          e_frame = 0, e_short = 0, e_partial = 0, e_ovf = 0;
    logic [23:0] m_acc = 24'd0;
    int          m_n = 0;
    bit          m_active = 1'b0;
    bit          m_valid = 1'b0;
    logic [23:0] m_word = 24'd0;

    function automatic void model_pulse(input int hi);
        m_active = 1'b1;
        if (hi < MIN) begin
            e_short++;
        end else begin
            m_acc = {m_acc[22:0], 1'(hi >= THRESH)};
            m_n++;
            if (m_n == 24) begin
                m_n = 0;
                if (ready)        exp_q.push_back(m_acc);
                else if (m_valid) e_ovf++;
                else begin
                    m_valid = 1'b1;
                    m_word  = m_acc;
                end
            end
        end
    endfunction

    function automatic void model_gap();
        if (m_active) e_frame++;
        if (m_n != 0) e_partial++;
        m_n      = 0;
        m_active = 1'b0;
    endfunction

    function automatic void model_reset();
        m_n      = 0;
        m_active = 1'b0;
        m_valid  = 1'b0;
    endfunction

    // Drivers
    task automatic send_pulse(input int hi, input int lo);
        model_pulse(hi);
        @(negedge clk);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        fall_cyc = cyc;
        repeat (lo - 1) @(negedge clk);
        if (lo >= RES + 50) model_gap();
    endtask

    task automatic send_word(input logic [23:0] w, input int zh, input int oh, input int per, input int last_lo);
        for (int i = 23; i >= 0; i--) begin
            int hi;
            hi = w[i] ? oh : zh;
            send_pulse(hi, (i == 0 && last_lo > 0) ? last_lo : per - hi);
        end
    endtask

    task automatic send_rand_bits(input int nbits, input int last_lo, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            int hi;
            if (i == glitch_at) send_pulse(5, 40);
            hi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(40, 70)) : int'($urandom_range(10, 39));
            send_pulse(hi, (i == nbits - 1 && last_lo > 0) ? last_lo : int'($urandom_range(20, 60)));
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 ready = v;
    endtask

    initial begin
        int lat;
        logic [23:0] w;
        rst = 1'b1; din = 1'b0; ready = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_pulses", 32'({frame_end, err_short, err_partial, overflow}), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Known word with nominal timing, latency from last fall
        send_word(24'hA5C30F, 26, 51, 80, 0);
        repeat (10) @(negedge clk);
        lat = accept_cyc - fall_cyc;
        check("latency_le4", 32'(lat >= 1 && lat <= 4), 32'd1);

        // Two random words back-to-back, then a latch gap
        send_rand_bits(24, 0, -1);
        send_rand_bits(24, GAP_LO, -1);
        check("frame_delay", 32'((frame_cyc - fall_cyc) >= RES - 5 && (frame_cyc - fall_cyc) <= RES + 10), 32'd1);

        // Consumer stalled across three words
        set_ready(1'b0);
        send_rand_bits(72, 0, -1);
        repeat (5) @(negedge clk);
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_data", 32'(data_out), 32'(m_word));
        set_ready(1'b1);
        if (m_valid) begin
            exp_q.push_back(m_word);
            m_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("valid_drop", 32'(valid), 32'd0);

        // Glitch mid-word
        send_rand_bits(24, 0, 12);

        // Partial word then gap, then a clean word
        send_rand_bits(10, GAP_LO, -1);
        send_rand_bits(24, 0, -1);

        // Width boundaries 39/40 and glitch boundary 9
        send_pulse(9, 40);
        w = 24'($urandom());
        send_word(w, THRESH - 1, THRESH, 80, GAP_LO);

        // Reset mid-word with a word pending
        set_ready(1'b0);
        send_rand_bits(24, 0, -1);
        send_rand_bits(10, 0, -1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_data", 32'(data_out), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_ready(1'b1);
        send_rand_bits(24, GAP_LO, -1);
        repeat (10) @(negedge clk);

        check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("cnt_frame_end", 32'(cnt_frame), 32'(e_frame));
        check("cnt_err_short", 32'(cnt_short), 32'(e_short));
        check("cnt_err_partial", 32'(cnt_partial), 32'(e_partial));
        check("cnt_overflow", 32'(cnt_ovf), 32'(e_ovf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
